letter_dispatcher: RTL and testbench



---
 rtl/letter_dispatcher_if.sv | 24 ++
 rtl/letter_dispatcher.sv | 164 ++++++++++++++++
 tb/tb_letter_dispatcher.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/letter_dispatcher_if.sv
// Column spawn channel: per-column busy/ready status in, one-hot offer and letter out.
// The dispatcher drives through the master modport; the column array uses the slave modport.
interface letter_dispatcher_if #(
  parameter int NUM_COLS = 3
);
  logic [NUM_COLS-1:0] col_busy;
  logic [NUM_COLS-1:0] spawn_ready;
  logic [NUM_COLS-1:0] spawn_valid;
  logic [7:0]          spawn_letter;

  modport master (
    input  col_busy,
    input  spawn_ready,
    output spawn_valid,
    output spawn_letter
  );

  modport slave (
    output col_busy,
    output spawn_ready,
    input  spawn_valid,
    input  spawn_letter
  );
endinterface

// File: rtl/letter_dispatcher.sv
// Spawn scheduler for the falling-letter columns: paces LFSR letters by a shrinking
// interval and hands each one to an idle column over a one-hot valid/ready handshake.
module letter_dispatcher #(
  parameter int          NUM_COLS    = 3,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int unsigned BASE_PERIOD = 50_000_000,
  parameter int unsigned MIN_PERIOD  = 12_500_000,
  parameter int unsigned STEP        = 1_000_000
) (
  input  logic                 clock,
  input  logic                 reset_signal,
  input  logic                 enable,
  input  logic [NUM_COLS-1:0]  correct,
  letter_dispatcher_if.master  col_if,
  output logic [3:0]           level
);

  localparam int          PTR_W     = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam logic [31:0] BASE_W    = 32'(BASE_PERIOD);
  localparam logic [31:0] MIN_W     = 32'(MIN_PERIOD);
  localparam logic [31:0] STEP_W    = 32'(STEP);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_OFFER = 2'd2;

  logic [1:0]          state_q,  state_d;
  logic [15:0]         lfsr_q,   lfsr_d;
  logic [31:0]         period_q, period_d;
  logic [31:0]         timer_q,  timer_d;
  logic [PTR_W-1:0]    ptr_q,    ptr_d;
  logic [PTR_W-1:0]    col_q,    col_d;
  logic [NUM_COLS-1:0] valid_q,  valid_d;
  logic [7:0]          letter_q, letter_d;
  logic [3:0]          level_q,  level_d;

  logic                found;
  logic [PTR_W-1:0]    pick;
  logic [PTR_W-1:0]    cand;

  // Shrink the interval by STEP per answered column, clamped at the floor without underflow.
  function automatic logic [31:0] next_period(input logic [31:0] cur,
                                              input logic [NUM_COLS-1:0] hits);
    logic [31:0] dec;
    logic [31:0] room;
    dec  = STEP_W * 32'($countones(hits));
    room = cur - MIN_W;
    if (dec >= room) return MIN_W;
    return cur - dec;
  endfunction

  function automatic logic [3:0] sat_level(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  function automatic logic [PTR_W-1:0] wrap_col(input logic [PTR_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_COLS) s = s - NUM_COLS;
    return PTR_W'(s);
  endfunction

  function automatic logic [7:0] nonzero_letter(input logic [7:0] raw);
    return (raw == 8'h00) ? 8'h01 : raw;
  endfunction

  // First idle column at or after the round-robin pointer.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 0; k < NUM_COLS; k++) begin
      cand = wrap_col(ptr_q, k);
      if (!found && !col_if.col_busy[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    ptr_d    = ptr_q;
    col_d    = col_q;
    valid_d  = valid_q;
    letter_d = letter_q;
    period_d = period_q;
    level_d  = level_q;
    lfsr_d   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);

    // Reloads below read period_q, so a same-edge correct pulse only affects later intervals.
    if (correct != '0) begin
      period_d = next_period(period_q, correct);
      if (period_q > MIN_W) level_d = sat_level(level_q);
    end

    if (!enable) begin
      state_d = S_IDLE;
      valid_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_WAIT;
          timer_d = period_q - 32'd1;
          valid_d = '0;
        end
        S_WAIT: begin
          if (timer_q != 32'd0) begin
            timer_d = timer_q - 32'd1;
          end else if (found) begin
            state_d       = S_OFFER;
            col_d         = pick;
            valid_d       = '0;
            valid_d[pick] = 1'b1;
            letter_d      = nonzero_letter(lfsr_q[7:0]);
          end
        end
        S_OFFER: begin
          if ((valid_q & col_if.spawn_ready) != '0) begin
            state_d = S_WAIT;
            valid_d = '0;
            timer_d = period_q - 32'd1;
            ptr_d   = (col_q == PTR_W'(NUM_COLS - 1)) ? '0 : col_q + 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          valid_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset_signal) begin
      state_q  <= S_IDLE;
      lfsr_q   <= LFSR_SEED;
      period_q <= BASE_W;
      timer_q  <= '0;
      ptr_q    <= '0;
      col_q    <= '0;
      valid_q  <= '0;
      letter_q <= '0;
      level_q  <= '0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      period_q <= period_d;
      timer_q  <= timer_d;
      ptr_q    <= ptr_d;
      col_q    <= col_d;
      valid_q  <= valid_d;
      letter_q <= letter_d;
      level_q  <= level_d;
    end
  end

  assign col_if.spawn_valid  = valid_q;
  assign col_if.spawn_letter = letter_q;
  assign level               = level_q;

endmodule

// File: tb/tb_letter_dispatcher.sv
// Scoreboard bench for letter_dispatcher: a behavioural model predicts offers and level
// changes; a negedge monitor pops and compares them as the DUT presents them.
module tb_letter_dispatcher;
  localparam int          NC   = 3;
  localparam int          BASE = 10;
  localparam int          MINP = 4;
  localparam int          STP  = 2;
  localparam logic [15:0] SEED = 16'hACE1;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [NC-1:0] corr;
  logic [3:0]    level;

  always #5 clk = ~clk;

  letter_dispatcher_if #(.NUM_COLS(NC)) cif ();

  letter_dispatcher #(
    .NUM_COLS(NC), .LFSR_SEED(SEED), .BASE_PERIOD(BASE), .MIN_PERIOD(MINP), .STEP(STP)
  ) dut (
    .clock(clk), .reset_signal(rst), .enable(en), .correct(corr),
    .col_if(cif.master), .level(level)
  );

  typedef struct {
    logic [NC-1:0] oh;
    logic [7:0]    letter;
    int            at;
  } offer_t;

  offer_t     exp_q[$];
  logic [3:0] lvl_q[$];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Model: mode 0 = idle, 1 = counting down, 2 = offering.
  int          m_mode   = 0;
  int          m_left   = 0;
  int          m_period = BASE;
  int          m_level  = 0;
  logic [15:0] m_lfsr   = SEED;
  int          m_ptr    = 0;
  int          m_col    = 0;
  logic [7:0]  m_letter = 8'h00;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [NC-1:0] onehot(int c);
    logic [NC-1:0] v;
    v = '0;
    v[c] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    if (m_level != 0) lvl_q.push_back(4'd0);
    m_mode = 0; m_left = 0; m_period = BASE; m_level = 0;
    m_lfsr = SEED; m_ptr = 0; m_col = 0; m_letter = 8'h00;
  endtask

  task automatic model_edge();
    logic [15:0] nl;
    int          np;
    int          sel;
    offer_t      o;
    if (rst) begin
      model_reset();
      return;
    end
    nl = m_lfsr >> 1;
    if (m_lfsr[0]) nl = nl ^ 16'hB400;
    np = m_period;
    if (corr != 0) begin
      np = m_period - STP * $countones(corr);
      if (np < MINP) np = MINP;
      if (m_period > MINP && m_level < 15) begin
        m_level++;
        lvl_q.push_back(4'(m_level));
      end
    end
    if (!en) begin
      m_mode = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
      m_left = m_period - 1;
    end else if (m_mode == 1) begin
      if (m_left > 0) begin
        m_left--;
      end else begin
        sel = -1;
        for (int k = 0; k < NC; k++)
          if (sel < 0 && !cif.col_busy[(m_ptr + k) % NC]) sel = (m_ptr + k) % NC;
        if (sel >= 0) begin
          m_mode   = 2;
          m_col    = sel;
          m_letter = (m_lfsr[7:0] == 8'h00) ? 8'h01 : m_lfsr[7:0];
          o.oh = onehot(sel); o.letter = m_letter; o.at = cyc;
          exp_q.push_back(o);
        end
      end
    end else begin
      if (cif.spawn_ready[m_col]) begin
        m_ptr  = (m_col + 1) % NC;
        m_left = m_period - 1;
        m_mode = 1;
      end
    end
    m_period = np;
    m_lfsr   = nl;
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
  endtask

  task automatic wait_rise(output int n);
    n = 0;
    while (n < 200) begin
      tick();
      n++;
      if (cif.spawn_valid != '0) break;
    end
    if (cif.spawn_valid == '0) begin
      tests++;
      fails++;
      $display("FAIL wait_rise: no offer within %0d cycles, expected one", n);
    end
  endtask

  // Monitor: per-cycle offer state, scoreboard pop on each rise, level changes.
  initial begin : monitor
    logic [NC-1:0] prev_v;
    logic [3:0]    prev_l;
    offer_t        o;
    prev_v = '0;
    prev_l = 4'd0;
    forever begin
      @(negedge clk);
      check("valid_vs_model", 32'(cif.spawn_valid),
            32'((m_mode == 2) ? onehot(m_col) : '0));
      if (m_mode == 2) check("letter_vs_model", 32'(cif.spawn_letter), 32'(m_letter));
      if (cif.spawn_valid != '0 && prev_v == '0) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL offer_unexpected: got %b expected no offer", cif.spawn_valid);
        end else begin
          o = exp_q.pop_front();
          check("offer_col", 32'(cif.spawn_valid), 32'(o.oh));
          check("offer_letter", 32'(cif.spawn_letter), 32'(o.letter));
          check("offer_cycle", cyc, o.at);
        end
      end
      if (level != prev_l) begin
        if (lvl_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL level_unexpected: got %0d expected %0d", level, prev_l);
        end else begin
          check("level_step", 32'(level), 32'(lvl_q.pop_front()));
        end
      end
      prev_v = cif.spawn_valid;
      prev_l = level;
    end
  end

  initial begin : driver
    int n;
    int bad;
    rst = 1'b1; en = 1'b0; corr = '0;
    cif.col_busy = '0; cif.spawn_ready = '1;
    repeat (3) tick();
    check("rst_valid", 32'(cif.spawn_valid), 32'd0);
    check("rst_letter", 32'(cif.spawn_letter), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    rst = 1'b0;

    // Back-to-back offers rotate through the columns.
    en = 1'b1;
    tick();
    wait_rise(n);
    check("first_interval", n, 10);
    check("first_col", 32'(cif.spawn_valid), 32'b001);
    wait_rise(n);
    check("second_interval", n, 11);
    check("second_col", 32'(cif.spawn_valid), 32'b010);
    wait_rise(n);
    check("third_col", 32'(cif.spawn_valid), 32'b100);

    // Pending: all busy at expiry, then column 2 frees up.
    en = 1'b0;
    tick();
    check("disable_low", 32'(cif.spawn_valid), 32'd0);
    cif.col_busy = 3'b111; cif.spawn_ready = '0; en = 1'b1;
    tick();
    bad = 0;
    repeat (15) begin
      tick();
      if (cif.spawn_valid != '0) bad++;
    end
    check("pending_quiet", bad, 0);
    cif.col_busy = 3'b011;
    tick();
    check("pending_col", 32'(cif.spawn_valid), 32'b100);

    // Ready withheld: offer holds, then transfers on first ready.
    bad = 0;
    repeat (20) begin
      tick();
      if (cif.spawn_valid != 3'b100) bad++;
    end
    check("hold_offer", bad, 0);
    cif.spawn_ready = '1; cif.col_busy = '0;
    tick();
    check("after_transfer_low", 32'(cif.spawn_valid), 32'd0);
    wait_rise(n);
    check("reload_interval", n, 10);

    // Correct pulses shrink the interval and raise the level.
    corr = 3'b011;
    tick();
    corr = '0;
    check("level_after_011", 32'(level), 32'd1);
    corr = 3'b001;
    tick();
    check("level_after_001a", 32'(level), 32'd2);
    tick();
    corr = '0;
    check("level_after_001b", 32'(level), 32'd2);
    wait_rise(n);
    tick();
    wait_rise(n);
    check("min_interval", n, 4);

    // Enable dropped mid-offer: abandoned, full interval after re-enable.
    tick();
    cif.spawn_ready = '0;
    wait_rise(n);
    en = 1'b0;
    tick();
    check("abandon_low", 32'(cif.spawn_valid), 32'd0);
    en = 1'b1;
    tick();
    cif.spawn_ready = '1;
    wait_rise(n);
    check("reenable_interval", n, 4);

    // Reset on the same edge as a valid & ready transfer.
    rst = 1'b1;
    tick();
    check("rst_xfer_valid", 32'(cif.spawn_valid), 32'd0);
    check("rst_xfer_letter", 32'(cif.spawn_letter), 32'd0);
    check("rst_xfer_level", 32'(level), 32'd0);
    rst = 1'b0;
    tick();
    wait_rise(n);
    check("post_rst_interval", n, 10);
    check("post_rst_col", 32'(cif.spawn_valid), 32'b001);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst  = ($urandom_range(0, 299) == 0);
      en   = ($urandom_range(0, 24) != 0);
      corr = ($urandom_range(0, 14) == 0) ? NC'($urandom) : '0;
      cif.col_busy    = NC'($urandom) & NC'($urandom);
      cif.spawn_ready = NC'($urandom);
      tick();
    end
    rst = 1'b0; corr = '0;
    repeat (3) tick();
    @(negedge clk);
    #1;
    check("offer_queue_drained", exp_q.size(), 0);
    check("level_queue_drained", lvl_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
